// File: rtl/exec_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exec_seq_pkg
//  Purpose  : Shared types and constants for the fetch/execute sequencer:
//             FSM state encoding, opcode constants and the halt marker.
//  Ports    : (package, no ports)
//  Revision : 1.0 - initial release
// ============================================================================
package exec_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_EXEC_MEM = 3'd3,
    ST_HALT     = 3'd4,
    ST_FAULT    = 3'd5
  } seq_state_t;

  localparam logic [3:0] OP_LDI   = 4'b1000;
  localparam logic [3:0] OP_LD    = 4'b1001;
  localparam logic [3:0] OP_ST    = 4'b1010;
  localparam logic [3:0] OP_CALL  = 4'b1101;
  localparam logic [3:0] OP_JMP   = 4'b1110;
  localparam logic [3:0] OP_EOE   = 4'b1111;
  localparam logic [3:0] EOE_HALT = 4'hF;

  // Load and store are the only opcodes that need a memory phase in EXEC.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_sequencer_return_stack.sv
`default_nettype none
// ============================================================================
//  Module   : return_stack
//  Purpose  : Hardware return-address stack (LIFO) with combinational top.
//  Ports    : clk, rst_n     - clock, synchronous active-low reset
//             i_clr          - synchronous clear (empties, zeroes entries)
//             i_push, i_pop  - push i_din / pop top (never both at once)
//             i_din          - address to push
//             o_top          - top entry, 0 when empty
//             o_full,o_empty - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module return_stack
  import exec_seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_din,
  output logic [PC_W-1:0] o_top,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [PTR_W:0]   r_ptr;
  logic [PC_W-1:0]  r_mem [STACK_DEPTH];
  logic [PTR_W-1:0] w_top_idx;

  assign o_empty   = (r_ptr == '0);
  assign o_full    = (r_ptr == (PTR_W+1)'(STACK_DEPTH));
  assign w_top_idx = r_ptr[PTR_W-1:0] - PTR_W'(1);
  assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_ptr <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !o_full) begin
      r_mem[r_ptr[PTR_W-1:0]] <= i_din;
      r_ptr                   <= r_ptr + (PTR_W+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr <= r_ptr - (PTR_W+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exec_sequencer
//  Purpose  : Multi-cycle fetch/execute sequencer with memory handshake,
//             request timeout, return-address stack and retire counter.
//  Ports    : clk, rst_n      - clock, synchronous active-low reset
//             i_start         - begin execution (IDLE/HALT only)
//             i_opcode, i_eoe - instruction opcode and end-of-exec field
//             i_pc            - current PC (call pushes i_pc+1)
//             i_mem_ready     - memory completes request this cycle
//             o_state         - 0 fetch / 1 execute, to control decoder
//             o_cpu_en        - one-cycle commit strobe
//             o_mem_req       - memory request, held until ready
//             o_ret_addr      - top of return stack (0 when empty)
//             o_halted, o_fault, o_busy - status
//             o_instr_count   - retired instructions, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [3:0]      i_opcode,
  input  logic [3:0]      i_eoe,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_mem_ready,
  output logic            o_state,
  output logic            o_cpu_en,
  output logic            o_mem_req,
  output logic [PC_W-1:0] o_ret_addr,
  output logic            o_halted,
  output logic            o_fault,
  output logic            o_busy,
  output logic [15:0]     o_instr_count
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [15:0]      r_instr_count;
  logic             w_tmo_last;
  logic             w_push;
  logic             w_pop;
  logic             w_clr;
  logic             w_full;
  logic             w_empty;
  logic             w_retire;

  return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_pc + PC_W'(1)),
    .o_top   (o_ret_addr),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Last permitted request cycle; a ready in this same cycle still wins.
  assign w_tmo_last = (r_tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    o_state      = 1'b0;
    o_cpu_en     = 1'b0;
    o_mem_req    = 1'b0;
    o_halted     = 1'b0;
    o_fault      = 1'b0;
    o_busy       = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        o_busy    = 1'b1;
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_cpu_en     = 1'b1;
          w_state_next = ST_EXEC;
        end else if (w_tmo_last) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_EXEC: begin
        o_state = 1'b1;
        o_busy  = 1'b1;
        if (is_mem_op(i_opcode)) begin
          o_mem_req = 1'b1;
          if (i_mem_ready) begin
            o_cpu_en     = 1'b1;
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_EXEC_MEM;
          end
        end else if (i_opcode == OP_CALL) begin
          if (w_full) begin
            w_state_next = ST_FAULT;
          end else begin
            w_push       = 1'b1;
            o_cpu_en     = 1'b1;
            w_state_next = ST_FETCH;
          end
        end else if (i_opcode == OP_EOE) begin
          if (i_eoe == EOE_HALT) begin
            w_state_next = ST_HALT;
          end else if (w_empty) begin
            w_state_next = ST_FAULT;
          end else begin
            w_pop        = 1'b1;
            o_cpu_en     = 1'b1;
            w_state_next = ST_FETCH;
          end
        end else begin
          o_cpu_en     = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_EXEC_MEM: begin
        o_state   = 1'b1;
        o_busy    = 1'b1;
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_cpu_en     = 1'b1;
          w_state_next = ST_FETCH;
        end else if (w_tmo_last) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_HALT: begin
        o_halted = 1'b1;
        if (i_start) begin
          w_clr        = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_FAULT: begin
        o_fault = 1'b1;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Only execute-phase commits retire an instruction; the fetch commit
  // merely loads IR.
  assign w_retire = o_cpu_en && ((r_state == ST_EXEC) || (r_state == ST_EXEC_MEM));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tmo_cnt     <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      // Every state change starts a fresh request window; FETCH and
      // EXEC_MEM are only ever entered from a different state.
      if (w_state_next != r_state) begin
        r_tmo_cnt <= '0;
      end else if (o_mem_req) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
      if (w_retire && (r_instr_count != 16'hFFFF)) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  assign o_instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_sequencer
//  Purpose  : Self-checking bench for exec_sequencer: directed scenarios plus
//             randomized episodes compared against a behavioural model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  // Model phases
  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_EXEC  = 2;
  localparam int P_EXMEM = 3;
  localparam int P_HALT  = 4;
  localparam int P_FAULT = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic [3:0]      i_opcode;
  logic [3:0]      i_eoe;
  logic [PC_W-1:0] i_pc;
  logic            i_mem_ready;
  logic            o_state;
  logic            o_cpu_en;
  logic            o_mem_req;
  logic [PC_W-1:0] o_ret_addr;
  logic            o_halted;
  logic            o_fault;
  logic            o_busy;
  logic [15:0]     o_instr_count;

  always #5 clk = ~clk;

  exec_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_opcode      (i_opcode),
    .i_eoe         (i_eoe),
    .i_pc          (i_pc),
    .i_mem_ready   (i_mem_ready),
    .o_state       (o_state),
    .o_cpu_en      (o_cpu_en),
    .o_mem_req     (o_mem_req),
    .o_ret_addr    (o_ret_addr),
    .o_halted      (o_halted),
    .o_fault       (o_fault),
    .o_busy        (o_busy),
    .o_instr_count (o_instr_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: phase, stack as a queue, retired count, and the
  // number of request cycles already spent in the current memory phase.
  int         m_phase = P_IDLE;
  logic [7:0] m_stack[$];
  int         m_count = 0;
  int         m_spent = 0;

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model to the state after the coming rising edge.
  task automatic step(input logic rn, input logic st, input logic [3:0] op,
                      input logic [3:0] eo, input logic [7:0] p, input logic rdy);
    logic [5:0] e;  // {state, cpu_en, mem_req, halted, fault, busy}
    int         nxt;
    logic       do_push, do_pop, do_clr;
    @(negedge clk);
    rst_n = rn; i_start = st; i_opcode = op; i_eoe = eo; i_pc = p; i_mem_ready = rdy;
    #1;
    e = 6'b0; nxt = m_phase; do_push = 1'b0; do_pop = 1'b0; do_clr = 1'b0;
    case (m_phase)
      P_IDLE: if (st) nxt = P_FETCH;
      P_FETCH, P_EXMEM: begin
        e = (m_phase == P_FETCH) ? 6'b001001 : 6'b101001;
        if (rdy) begin
          e[4] = 1'b1;
          nxt  = (m_phase == P_FETCH) ? P_EXEC : P_FETCH;
        end else if (m_spent + 1 >= TMO) begin
          nxt = P_FAULT;
        end
      end
      P_EXEC: begin
        e = 6'b100001;
        if (op == 4'b1001 || op == 4'b1010) begin
          e[3] = 1'b1;
          if (rdy) begin e[4] = 1'b1; nxt = P_FETCH; end
          else nxt = P_EXMEM;
        end else if (op == 4'b1101) begin
          if (m_stack.size() >= DEPTH) nxt = P_FAULT;
          else begin e[4] = 1'b1; do_push = 1'b1; nxt = P_FETCH; end
        end else if (op == 4'b1111 && eo == 4'b1111) begin
          nxt = P_HALT;
        end else if (op == 4'b1111) begin
          if (m_stack.size() == 0) nxt = P_FAULT;
          else begin e[4] = 1'b1; do_pop = 1'b1; nxt = P_FETCH; end
        end else begin
          e[4] = 1'b1; nxt = P_FETCH;
        end
      end
      P_HALT: begin
        e = 6'b000100;
        if (st) begin nxt = P_FETCH; do_clr = 1'b1; end
      end
      default: e = 6'b000010;
    endcase
    check_eq("outs{state,en,req,halt,fault,busy}",
             {o_state, o_cpu_en, o_mem_req, o_halted, o_fault, o_busy}, e);
    check_eq("ret_addr", o_ret_addr, (m_stack.size() == 0) ? 8'h00 : m_stack[$]);
    check_eq("instr_count", o_instr_count, m_count);
    if (!rn) begin
      m_phase = P_IDLE; m_stack.delete(); m_count = 0; m_spent = 0;
    end else begin
      if (e[4] && m_phase != P_FETCH && m_count < 65535) m_count++;
      if (do_clr) m_stack.delete();
      if (do_push) m_stack.push_back(p + 8'd1);
      if (do_pop) void'(m_stack.pop_back());
      if (nxt == m_phase) m_spent++;
      else m_spent = 0;
      m_phase = nxt;
    end
  endtask

  task automatic idle_cyc(input logic st);       step(1'b1, st, 4'h0, 4'h0, 8'h00, 1'b0); endtask
  task automatic fetch(input logic rdy);          step(1'b1, 1'b0, 4'h0, 4'h0, 8'h00, rdy); endtask
  task automatic exec(input logic [3:0] op, input logic [3:0] eo,
                      input logic [7:0] p, input logic rdy);
    step(1'b1, 1'b0, op, eo, p, rdy);
  endtask
  task automatic do_reset();                      step(1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0); endtask

  initial begin
    int pr;
    int r;
    logic [3:0] op, eo;

    rst_n = 1'b0; i_start = 1'b0; i_opcode = '0; i_eoe = '0; i_pc = '0; i_mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    idle_cyc(1'b0);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_icnt", o_instr_count, 16'd0);

    // Three ALU ops then halt, zero-wait memory
    idle_cyc(1'b1);
    for (int k = 0; k < 3; k++) begin
      fetch(1'b1);
      check_eq("prog_fetch_en", o_cpu_en, 1'b1);
      exec(4'b0001, 4'h0, 8'(k), 1'b1);
      check_eq("prog_exec_en", o_cpu_en, 1'b1);
    end
    fetch(1'b1);
    exec(4'hF, 4'hF, 8'h03, 1'b1);
    check_eq("halt_no_en", o_cpu_en, 1'b0);
    idle_cyc(1'b0);
    check_eq("halted", o_halted, 1'b1);
    check_eq("prog_icnt", o_instr_count, 16'd3);

    // Load with 3 wait cycles, restarted from HALT
    idle_cyc(1'b1);
    fetch(1'b1);
    exec(4'b1001, 4'h0, 8'h04, 1'b0);
    check_eq("ld_exec_req", o_mem_req, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exec(4'b1001, 4'h0, 8'h04, 1'b0);
      check_eq("ld_wait_req", {o_mem_req, o_cpu_en}, 2'b10);
    end
    exec(4'b1001, 4'h0, 8'h04, 1'b1);
    check_eq("ld_ready_en", {o_mem_req, o_cpu_en}, 2'b11);
    fetch(1'b0);
    check_eq("ld_back_fetch", o_state, 1'b0);
    check_eq("ld_icnt", o_instr_count, 16'd4);

    // Call then return
    fetch(1'b1);
    exec(4'b1101, 4'h0, 8'h10, 1'b0);
    fetch(1'b1);
    check_eq("call_ret_addr", o_ret_addr, 8'h11);
    exec(4'hF, 4'h0, 8'h30, 1'b0);
    check_eq("ret_exec_addr", o_ret_addr, 8'h11);
    fetch(1'b0);
    check_eq("ret_popped", o_ret_addr, 8'h00);

    // Stack overflow on the 5th nested call
    for (int k = 0; k < 4; k++) begin
      fetch(1'b1);
      exec(4'b1101, 4'h0, 8'(8'h20 + k), 1'b0);
    end
    fetch(1'b1);
    exec(4'b1101, 4'h0, 8'h24, 1'b0);
    check_eq("ovf_no_en", o_cpu_en, 1'b0);
    idle_cyc(1'b1);
    check_eq("ovf_fault", o_fault, 1'b1);
    idle_cyc(1'b1);
    check_eq("fault_sticky", {o_fault, o_busy}, 2'b10);
    do_reset();
    idle_cyc(1'b0);
    check_eq("fault_cleared", o_fault, 1'b0);

    // Fetch timeout, then ready arriving on the last permitted cycle
    idle_cyc(1'b1);
    for (int k = 0; k < TMO; k++) fetch(1'b0);
    idle_cyc(1'b0);
    check_eq("tmo_fault", o_fault, 1'b1);
    do_reset();
    idle_cyc(1'b1);
    for (int k = 0; k < TMO - 1; k++) fetch(1'b0);
    fetch(1'b1);
    check_eq("tmo_ready_wins", o_cpu_en, 1'b1);
    exec(4'b0010, 4'h0, 8'h00, 1'b0);
    check_eq("tmo_in_exec", {o_state, o_fault}, 2'b10);

    // Reset in the middle of EXEC_MEM
    fetch(1'b1);
    exec(4'b1010, 4'h0, 8'h01, 1'b0);
    exec(4'b1010, 4'h0, 8'h01, 1'b0);
    do_reset();
    idle_cyc(1'b0);
    check_eq("midrst_outs", {o_state, o_cpu_en, o_mem_req, o_halted, o_fault, o_busy}, 6'b0);
    check_eq("midrst_icnt", o_instr_count, 16'd0);

    // Randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      idle_cyc(1'b1);
      case (ep % 4)
        0: pr = 100;
        1: pr = 70;
        2: pr = 40;
        default: pr = 4;
      endcase
      for (int c = 0; c < 150; c++) begin
        r  = int'($urandom_range(0, 7));
        eo = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        case (r)
          0: op = 4'hF;
          1: op = 4'hD;
          2: op = ($urandom_range(0, 1) == 0) ? 4'h9 : 4'hA;
          default: op = 4'($urandom);
        endcase
        step(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) == 0), op, eo,
             8'($urandom), (int'($urandom_range(0, 99)) < pr));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
